// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: command FIFO in front of the arithmetic unit. Commands are
// issued one at a time with a single-cycle enable strobe. The unit's result is
// captured in the single cycle it is valid and offered on a valid/ready port.
// Divide-by-zero commands never reach the unit; they are answered locally.
module alu_cmd_sequencer #(
  parameter int Operand_SIZE = 16,
  parameter int ALU_OUT      = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          Cmd_Valid,
  output logic                          Cmd_Ready,
  input  logic [Operand_SIZE-1:0]       Cmd_A,
  input  logic [Operand_SIZE-1:0]       Cmd_B,
  input  logic [1:0]                    Cmd_FUN,
  output logic [Operand_SIZE-1:0]       A,
  output logic [Operand_SIZE-1:0]       B,
  output logic [1:0]                    ALU_FUN,
  output logic                          Arith_Enable,
  input  logic [ALU_OUT-1:0]            Arith_out,
  input  logic                          Carry_OUT,
  output logic                          Res_Valid,
  input  logic                          Res_Ready,
  output logic [ALU_OUT-1:0]            Res_Data,
  output logic                          Res_Carry,
  output logic [1:0]                    Res_FUN,
  output logic                          Res_DivZero,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_Count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = 2 * Operand_SIZE + 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t state, next_state;

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  logic [EW-1:0]           head;
  logic [Operand_SIZE-1:0] head_a, head_b;
  logic [1:0]              head_fun;
  logic                    head_divz;
  logic                    fifo_empty;
  logic                    push, pop;
  logic                    issue, trap, capture, res_release;

  assign head      = mem[rd_ptr];
  assign head_a    = head[EW-1 -: Operand_SIZE];
  assign head_b    = head[Operand_SIZE+1 -: Operand_SIZE];
  assign head_fun  = head[1:0];
  assign head_divz = (head_fun == 2'b11) && (head_b == '0);

  assign fifo_empty = (Fifo_Count == '0);
  assign Cmd_Ready  = (Fifo_Count < DEPTH_C);
  assign push       = Cmd_Valid && Cmd_Ready;

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; HOLD may go straight into the next command when the result is taken.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (pop) next_state = head_divz ? HOLD : ISSUE;
      ISSUE:   next_state = WAIT;
      WAIT:    next_state = HOLD;
      HOLD: begin
        if (Res_Ready) begin
          if (pop) next_state = head_divz ? HOLD : ISSUE;
          else     next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Control decode: when to pop, issue, trap, capture and release the result.
  always_comb begin
    pop         = 1'b0;
    capture     = 1'b0;
    res_release = 1'b0;
    case (state)
      IDLE: pop = !fifo_empty;
      WAIT: capture = 1'b1;
      HOLD: begin
        res_release = Res_Ready;
        pop         = Res_Ready && !fifo_empty;
      end
      default: ;
    endcase
    issue = pop && !head_divz;
    trap  = pop && head_divz;
  end

  // FIFO storage is written only on an accepted push; contents need no reset.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {Cmd_A, Cmd_B, Cmd_FUN};
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Fifo_Count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   Fifo_Count <= Fifo_Count + ONE_C;
        2'b01:   Fifo_Count <= Fifo_Count - ONE_C;
        default: Fifo_Count <= Fifo_Count;
      endcase
    end
  end

  // Operands and opcode change only at issue; the enable strobe lasts one cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      A            <= '0;
      B            <= '0;
      ALU_FUN      <= '0;
      Arith_Enable <= 1'b0;
    end else begin
      Arith_Enable <= issue;
      if (issue) begin
        A       <= head_a;
        B       <= head_b;
        ALU_FUN <= head_fun;
      end
    end
  end

  // Result register: loaded on capture or trap, held until the next one.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Res_Valid   <= 1'b0;
      Res_Data    <= '0;
      Res_Carry   <= 1'b0;
      Res_FUN     <= '0;
      Res_DivZero <= 1'b0;
    end else begin
      if (capture) begin
        Res_Valid   <= 1'b1;
        Res_Data    <= Arith_out;
        Res_Carry   <= Carry_OUT;
        Res_FUN     <= ALU_FUN;
        Res_DivZero <= 1'b0;
      end else if (trap) begin
        Res_Valid   <= 1'b1;
        Res_Data    <= '0;
        Res_Carry   <= 1'b0;
        Res_FUN     <= 2'b11;
        Res_DivZero <= 1'b1;
      end else if (res_release) begin
        Res_Valid   <= 1'b0;
      end
    end
  end

endmodule
